eth_fcs_check_arb: RTL and testbench

Frame-granular round-robin arbiter that shares one 64-bit Ethernet FCS checker among S_COUNT AXI4-Stream sources. It grants one source per frame and muxes that source onto the checker input. It keeps an in-order tag FIFO of granted source IDs, and monitors the checker's output stream so every frame leaving the checker is labelled with its source ID.

---
 rtl/eth_fcs_arb_pkg.sv | 17 +
 rtl/eth_fcs_arb_tag_fifo.sv | 49 ++++
 rtl/eth_fcs_check_arb.sv | 181 ++++++++++++++++++
 tb/tb_eth_fcs_check_arb.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_fcs_arb_pkg.sv
// Shared definitions for the FCS checker arbiter: stream widths, FSM state
// encoding and the source-ID width helper.
package eth_fcs_arb_pkg;

    localparam int DATA_W = 64;
    localparam int KEEP_W = 8;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } arb_state_t;

    function automatic int tid_width(input int s_count);
        return (s_count > 1) ? $clog2(s_count) : 1;
    endfunction

endpackage

// File: rtl/eth_fcs_arb_tag_fifo.sv
// In-order FIFO of granted source IDs. The head is presented combinationally
// (first-word fall-through) and reads 0 while empty. A pop of an empty FIFO
// is ignored; push and pop in the same cycle both take effect, including
// when the FIFO is full.
module eth_fcs_arb_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // pointer update; the extra MSB distinguishes full from empty
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // storage needs no reset: the head is masked while empty
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/eth_fcs_check_arb.sv
// Frame-granular round-robin arbiter sharing one FCS checker among S_COUNT
// AXI4-Stream sources, with an in-order tag FIFO that labels each frame
// leaving the checker with its source ID.
// Optional per-port statistics: define ETH_FCS_ARB_STATS_EN.
//
//   state  | meaning
//   IDLE   | no grant; pick next requester when a tag slot is available
//   ACTIVE | grant_q muxed onto the checker until its tlast is accepted
module eth_fcs_check_arb
    import eth_fcs_arb_pkg::*;
#(
    parameter int S_COUNT   = 4,
    parameter int TAG_DEPTH = 4,
    parameter int CNT_WIDTH = 32,
    parameter int TID_WIDTH = tid_width(S_COUNT)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [S_COUNT*DATA_W-1:0]    s_axis_tdata,
    input  logic [S_COUNT*KEEP_W-1:0]    s_axis_tkeep,
    input  logic [S_COUNT-1:0]           s_axis_tvalid,
    output logic [S_COUNT-1:0]           s_axis_tready,
    input  logic [S_COUNT-1:0]           s_axis_tlast,
    input  logic [S_COUNT-1:0]           s_axis_tuser,
    output logic [DATA_W-1:0]            chk_axis_tdata,
    output logic [KEEP_W-1:0]            chk_axis_tkeep,
    output logic                         chk_axis_tvalid,
    input  logic                         chk_axis_tready,
    output logic                         chk_axis_tlast,
    output logic                         chk_axis_tuser,
    input  logic                         mon_tvalid,
    input  logic                         mon_tready,
    input  logic                         mon_tlast,
    input  logic                         mon_tuser,
    output logic [TID_WIDTH-1:0]         mon_tid,
    output logic                         mon_tid_valid,
    output logic                         tag_underflow,
    output logic                         busy,
    output logic [S_COUNT*CNT_WIDTH-1:0] stat_frames,
    output logic [S_COUNT*CNT_WIDTH-1:0] stat_bad
);

    localparam logic [TID_WIDTH-1:0] LAST_ID = TID_WIDTH'(S_COUNT - 1);

    arb_state_t           state_q, state_d;
    logic [TID_WIDTH-1:0] grant_q, grant_d;
    logic [TID_WIDTH-1:0] ptr_q, ptr_d;
    logic [TID_WIDTH-1:0] pick_id;
    logic                 pick_found;
    logic                 tag_push;
    logic                 mon_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 underflow_q;

    assign mon_pop       = mon_tvalid && mon_tready && mon_tlast;
    assign mon_tid_valid = !fifo_empty;
    assign tag_underflow = underflow_q;
    assign busy          = (state_q == ACTIVE);

    eth_fcs_arb_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .WIDTH (TID_WIDTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tag_push),
        .push_data (grant_d),
        .pop       (mon_pop),
        .head      (mon_tid),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // round-robin search: first requester at or after the pointer, wrapping
    always_comb begin
        int                   idx;
        logic [TID_WIDTH-1:0] cand;
        idx        = 0;
        cand       = '0;
        pick_found = 1'b0;
        pick_id    = '0;
        for (int i = 0; i < S_COUNT; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= S_COUNT) idx = idx - S_COUNT;
            cand = idx[TID_WIDTH-1:0];
            if (!pick_found && s_axis_tvalid[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    // next-state: grant when a tag slot is free (a same-cycle pop frees one)
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        tag_push = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found && (!fifo_full || mon_pop)) begin
                    grant_d  = pick_id;
                    tag_push = 1'b1;
                    state_d  = ACTIVE;
                end
            end
            ACTIVE: begin
                if (chk_axis_tvalid && chk_axis_tready && chk_axis_tlast) begin
                    ptr_d   = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // combinational mux of the granted source onto the checker input
    always_comb begin
        chk_axis_tdata  = '0;
        chk_axis_tkeep  = '0;
        chk_axis_tvalid = 1'b0;
        chk_axis_tlast  = 1'b0;
        chk_axis_tuser  = 1'b0;
        s_axis_tready   = '0;
        if (state_q == ACTIVE) begin
            chk_axis_tdata         = s_axis_tdata[int'(grant_q)*DATA_W +: DATA_W];
            chk_axis_tkeep         = s_axis_tkeep[int'(grant_q)*KEEP_W +: KEEP_W];
            chk_axis_tvalid        = s_axis_tvalid[grant_q];
            chk_axis_tlast         = s_axis_tlast[grant_q];
            chk_axis_tuser         = s_axis_tuser[grant_q];
            s_axis_tready[grant_q] = chk_axis_tready;
        end
    end

    // arbiter state registers and underflow pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            ptr_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            underflow_q <= mon_pop && fifo_empty;
        end
    end

`ifdef ETH_FCS_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] frames_q [S_COUNT];
    logic [CNT_WIDTH-1:0] bad_q    [S_COUNT];

    // saturating per-port counters, attributed to the tag at the FIFO head
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < S_COUNT; i++) begin
                frames_q[i] <= '0;
                bad_q[i]    <= '0;
            end
        end else if (mon_pop && !fifo_empty) begin
            if (frames_q[mon_tid] != '1)
                frames_q[mon_tid] <= frames_q[mon_tid] + 1'b1;
            if (mon_tuser && (bad_q[mon_tid] != '1))
                bad_q[mon_tid] <= bad_q[mon_tid] + 1'b1;
        end
    end

    for (genvar g = 0; g < S_COUNT; g++) begin : g_stat
        assign stat_frames[g*CNT_WIDTH +: CNT_WIDTH] = frames_q[g];
        assign stat_bad[g*CNT_WIDTH +: CNT_WIDTH]    = bad_q[g];
    end
`else
    logic unused_mon_tuser;
    assign unused_mon_tuser = mon_tuser;
    assign stat_frames      = {S_COUNT*CNT_WIDTH{1'b0}};
    assign stat_bad         = {S_COUNT*CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_eth_fcs_check_arb.sv
// Scoreboard bench for eth_fcs_check_arb. Stimulus tasks queue source beats
// and push the expected checker beats and source tags; a negedge monitor
// pops and compares whenever the DUT presents a beat or the bench pops a tag.
module tb_eth_fcs_check_arb;

    localparam int S  = 4;
    localparam int TD = 4;
    localparam int CW = 32;
    localparam int TW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [S*64-1:0] s_axis_tdata  = '0;
    logic [S*8-1:0]  s_axis_tkeep  = '0;
    logic [S-1:0]    s_axis_tvalid = '0;
    logic [S-1:0]    s_axis_tready;
    logic [S-1:0]    s_axis_tlast  = '0;
    logic [S-1:0]    s_axis_tuser  = '0;
    logic [63:0]     chk_axis_tdata;
    logic [7:0]      chk_axis_tkeep;
    logic            chk_axis_tvalid;
    logic            chk_axis_tready = 1'b1;
    logic            chk_axis_tlast;
    logic            chk_axis_tuser;
    logic            mon_tvalid = 1'b0;
    logic            mon_tready = 1'b0;
    logic            mon_tlast  = 1'b0;
    logic            mon_tuser  = 1'b0;
    logic [TW-1:0]   mon_tid;
    logic            mon_tid_valid;
    logic            tag_underflow;
    logic            busy;
    logic [S*CW-1:0] stat_frames;
    logic [S*CW-1:0] stat_bad;

    eth_fcs_check_arb #(
        .S_COUNT   (S),
        .TAG_DEPTH (TD),
        .CNT_WIDTH (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tkeep    (s_axis_tkeep),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tuser    (s_axis_tuser),
        .chk_axis_tdata  (chk_axis_tdata),
        .chk_axis_tkeep  (chk_axis_tkeep),
        .chk_axis_tvalid (chk_axis_tvalid),
        .chk_axis_tready (chk_axis_tready),
        .chk_axis_tlast  (chk_axis_tlast),
        .chk_axis_tuser  (chk_axis_tuser),
        .mon_tvalid      (mon_tvalid),
        .mon_tready      (mon_tready),
        .mon_tlast       (mon_tlast),
        .mon_tuser       (mon_tuser),
        .mon_tid         (mon_tid),
        .mon_tid_valid   (mon_tid_valid),
        .tag_underflow   (tag_underflow),
        .busy            (busy),
        .stat_frames     (stat_frames),
        .stat_bad        (stat_bad)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
    } beat_t;

    beat_t src_q [S][$];
    beat_t exp_chk[$];
    int    exp_tag[$];
    int    beat_cyc[$];

    int    n_pass = 0;
    int    n_tot  = 0;
    int    cyc    = 0;
    int    first_req = -1;
    int    viol   = 0;
    int    pop_cyc = 0;
    bit    watch0 = 1'b0;
    bit    exp_uf = 1'b0;
    logic [S-1:0] hs = '0;
    beat_t mon_e;
    beat_t drv_b;
    int    mon_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // source driver: retire accepted beats, present the next one
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < S; i++) begin
                if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    drv_b = src_q[i][0];
                    s_axis_tdata[64*i +: 64] = drv_b.data;
                    s_axis_tkeep[8*i +: 8]   = drv_b.keep;
                    s_axis_tlast[i]          = drv_b.last;
                    s_axis_tuser[i]          = drv_b.user;
                    s_axis_tvalid[i]         = 1'b1;
                end else begin
                    s_axis_tdata[64*i +: 64] = '0;
                    s_axis_tkeep[8*i +: 8]   = '0;
                    s_axis_tlast[i]          = 1'b0;
                    s_axis_tuser[i]          = 1'b0;
                    s_axis_tvalid[i]         = 1'b0;
                end
            end
        end
    end

    // monitor: compare checker beats and popped tags against the scoreboard
    always @(negedge clk) begin
        hs = s_axis_tvalid & s_axis_tready;
        if (!rst) begin
            if (exp_uf || tag_underflow) check("tag_underflow", tag_underflow, exp_uf);
            exp_uf = 1'b0;
            if (first_req < 0 && |s_axis_tvalid) first_req = cyc;
            if (watch0 && s_axis_tready[0]) viol++;
            if (chk_axis_tvalid && chk_axis_tready) begin
                beat_cyc.push_back(cyc);
                if (exp_chk.size() == 0) begin
                    n_tot++;
                    $display("FAIL chk_beat: unexpected beat data %h, none expected", chk_axis_tdata);
                end else begin
                    mon_e = exp_chk.pop_front();
                    check("chk_tdata", chk_axis_tdata, mon_e.data);
                    check("chk_tkeep", chk_axis_tkeep, mon_e.keep);
                    check("chk_tlast", chk_axis_tlast, mon_e.last);
                    check("chk_tuser", chk_axis_tuser, mon_e.user);
                end
                if (chk_axis_tlast && chk_axis_tdata[63:56] == 8'hA2) watch0 = 1'b0;
            end
            if (mon_tvalid && mon_tready && mon_tlast) begin
                if (exp_tag.size() > 0) begin
                    mon_t = exp_tag.pop_front();
                    check("mon_tid", mon_tid, mon_t);
                    check("mon_tid_valid", mon_tid_valid, 1);
                end else begin
                    check("mon_tid_valid_empty", mon_tid_valid, 0);
                    exp_uf = 1'b1;
                end
            end
        end
    end

    task automatic send_frame(input int port, input int fid, input int nb,
                              input logic [7:0] lkeep, input logic user);
        beat_t b;
        for (int k = 0; k < nb; k++) begin
            b.data = {8'(8'hA0 + port), 8'(fid), 8'(k), 40'h00C0FFEE00};
            b.last = (k == nb - 1);
            b.keep = b.last ? lkeep : 8'hFF;
            b.user = b.last ? user : 1'b0;
            src_q[port].push_back(b);
            exp_chk.push_back(b);
        end
        exp_tag.push_back(port);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        for (int i = 0; i < S; i++) src_q[i].delete();
        exp_chk.delete();
        exp_tag.delete();
        exp_uf = 1'b0;
        watch0 = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic mon_pop(input logic user);
        @(posedge clk);
        #1;
        mon_tvalid = 1'b1;
        mon_tready = 1'b1;
        mon_tlast  = 1'b1;
        mon_tuser  = user;
        pop_cyc    = cyc;
        @(posedge clk);
        #1;
        mon_tvalid = 1'b0;
        mon_tready = 1'b0;
        mon_tlast  = 1'b0;
        mon_tuser  = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        bit done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clk);
            if (exp_chk.size() == 0 && !busy) done = 1'b1;
        end
        if (!done) begin
            n_tot++;
            $display("FAIL %s: timeout with %0d beats outstanding, need 0", name, exp_chk.size());
        end
    endtask

    task automatic wait_sig(input string name, input bit want_busy, input int budget);
        bit done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clk);
            if (want_busy ? busy : mon_tid_valid) done = 1'b1;
        end
        if (!done) begin
            n_tot++;
            $display("FAIL %s: timeout, signal stayed 0, need 1", name);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        do_reset();
        @(negedge clk);
        check("rst_s_tready", s_axis_tready, 0);
        check("rst_chk_tvalid", chk_axis_tvalid, 0);
        check("rst_chk_tdata", chk_axis_tdata, 0);
        check("rst_mon_tid_valid", mon_tid_valid, 0);
        check("rst_mon_tid", mon_tid, 0);
        check("rst_tag_underflow", tag_underflow, 0);
        check("rst_busy", busy, 0);
        check("rst_stat_frames", stat_frames[63:0], 0);

        // single 3-beat frame on port 1
        first_req = -1;
        beat_cyc.delete();
        send_frame(1, 1, 3, 8'h07, 1'b0);
        wait_drain("t1_drain", 40);
        check("t1_beats", beat_cyc.size(), 3);
        if (beat_cyc.size() == 3) begin
            check("t1_latency", beat_cyc[0] - first_req, 1);
            check("t1_back_to_back", beat_cyc[2] - beat_cyc[0], 2);
        end
        check("t1_idle_busy", busy, 0);
        check("t1_idle_tvalid", chk_axis_tvalid, 0);
        mon_pop(1'b0);
        @(negedge clk);
        check("t1_tag_empty", mon_tid_valid, 0);

        // round robin among ports 0, 2, 3 with single-beat frames
        do_reset();
        first_req = -1;
        beat_cyc.delete();
        send_frame(0, 1, 1, 8'h01, 1'b0);
        send_frame(2, 1, 1, 8'h03, 1'b0);
        send_frame(3, 1, 1, 8'h07, 1'b0);
        send_frame(0, 2, 1, 8'h0F, 1'b0);
        send_frame(2, 2, 1, 8'h1F, 1'b0);
        send_frame(3, 2, 1, 8'h3F, 1'b0);
        fork
            wait_drain("t2_drain", 80);
            begin
                for (int k = 0; k < 6; k++) begin
                    wait_sig("t2_tag_wait", 1'b0, 20);
                    mon_pop(1'b0);
                end
            end
        join
        check("t2_beats", beat_cyc.size(), 6);
        if (beat_cyc.size() == 6) begin
            check("t2_latency", beat_cyc[0] - first_req, 1);
            for (int k = 1; k < 6; k++) check("t2_one_bubble", beat_cyc[k] - beat_cyc[k-1], 2);
        end

        // tready toggling mid-frame on port 2 while port 0 waits
        do_reset();
        send_frame(2, 1, 4, 8'h3F, 1'b1);
        wait_sig("t3_busy", 1'b1, 20);
        viol   = 0;
        watch0 = 1'b1;
        send_frame(0, 1, 1, 8'hFF, 1'b0);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            chk_axis_tready = (k % 2 == 0);
        end
        @(posedge clk);
        #1;
        chk_axis_tready = 1'b1;
        wait_drain("t3_drain", 40);
        check("t3_port0_held", viol, 0);
        check("t3_port2_done", watch0, 0);
        mon_pop(1'b0);
        mon_pop(1'b0);

        // tag FIFO full blocks the fifth grant until one pop
        do_reset();
        beat_cyc.delete();
        send_frame(0, 1, 1, 8'hFF, 1'b0);
        send_frame(1, 1, 1, 8'hFF, 1'b0);
        send_frame(2, 1, 1, 8'hFF, 1'b0);
        send_frame(3, 1, 1, 8'hFF, 1'b0);
        send_frame(0, 2, 1, 8'h0F, 1'b0);
        repeat (20) @(negedge clk);
        check("t4_beats_before_pop", beat_cyc.size(), 4);
        check("t4_no_grant", busy, 0);
        check("t4_head_tid", mon_tid, 0);
        beat_cyc.delete();
        mon_pop(1'b0);
        wait_drain("t4_drain", 20);
        check("t4_beats_after_pop", beat_cyc.size(), 1);
        if (beat_cyc.size() == 1) check("t4_grant_after_pop", beat_cyc[0] - pop_cyc, 1);
        for (int k = 0; k < 4; k++) mon_pop(1'b0);

        // pop with an empty tag FIFO
        mon_pop(1'b0);
        repeat (3) @(negedge clk);
        check("t5_still_empty", mon_tid_valid, 0);
        send_frame(1, 9, 1, 8'hFF, 1'b0);
        wait_drain("t5_drain", 20);
        mon_pop(1'b0);

`ifdef ETH_FCS_ARB_STATS_EN
        do_reset();
        send_frame(3, 1, 2, 8'hFF, 1'b0);
        send_frame(3, 2, 2, 8'hFF, 1'b0);
        send_frame(3, 3, 2, 8'hFF, 1'b0);
        wait_drain("t6_drain", 60);
        mon_pop(1'b0);
        mon_pop(1'b0);
        mon_pop(1'b1);
        repeat (2) @(negedge clk);
        check("t6_frames3", stat_frames[3*CW +: CW], 3);
        check("t6_bad3", stat_bad[3*CW +: CW], 1);
        check("t6_frames0", stat_frames[0 +: CW], 0);
`endif

        // reset in the middle of a frame
        chk_axis_tready = 1'b0;
        send_frame(3, 7, 4, 8'hFF, 1'b0);
        wait_sig("t7_busy", 1'b1, 20);
        do_reset();
        @(negedge clk);
        check("t7_busy", busy, 0);
        check("t7_s_tready", s_axis_tready, 0);
        check("t7_chk_tvalid", chk_axis_tvalid, 0);
        check("t7_tag_valid", mon_tid_valid, 0);
        check("t7_stat_frames", stat_frames[3*CW +: CW], 0);
        check("t7_stat_bad", stat_bad[3*CW +: CW], 0);
        chk_axis_tready = 1'b1;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
